apb_bridge_nslave: RTL

//  Parametrised APB master bridge plus N-slave interconnect; successor to the fixed two-slave GPIO/UART top.

---
 rtl/apb_bridge_nslave.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/apb_bridge_nslave.sv
// APB master bridge with an N-slave address decoder.
// Accepts valid/ready requests, runs SETUP/ACCESS with wait-state timeout, returns a 1-cycle response.
module apb_bridge_nslave #(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned SLV_AW  = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_wdata,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [NSLV-1:0]    PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [AW-1:0]      PADDR,
  output logic [DW-1:0]      PWDATA,
  input  logic [NSLV*DW-1:0] PRDATA,
  input  logic [NSLV-1:0]    PREADY,
  input  logic [NSLV-1:0]    PSLVERR
);

  localparam int unsigned IW = AW - SLV_AW;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DERR   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]   req_idx;
  logic [NSLV-1:0] req_onehot;
  logic            idx_ok;
  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;
  logic            timeout_hit;

  assign req_idx = req_addr[AW-1:SLV_AW];
  assign idx_ok  = 32'(req_idx) < NSLV;

  always_comb begin
    req_onehot = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      req_onehot[i] = (32'(req_idx) == i);
    end
  end

  // psel_q is one-hot, so masking picks out the selected slave and ignores the rest.
  assign sel_ready = |(PREADY & psel_q);
  assign sel_err   = |(PSLVERR & psel_q);

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (psel_q[i]) sel_rdata = PRDATA[i*DW +: DW];
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          if (idx_ok) begin
            psel_d  = req_onehot;
            state_d = SETUP;
          end else begin
            state_d = DERR;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DERR: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
